// File: rtl/video_pattern_gen.sv
// Synthetic framed video source: one header line, V_ACTIVE numbered data lines, V_BLANK blank lines.
// Outputs are registered one cycle behind the h/v counters; supports one-shot data-line error injection.
module video_pattern_gen #(
  parameter int H_ACTIVE = 16,
  parameter int H_BLANK  = 8,
  parameter int V_ACTIVE = 8,
  parameter int V_BLANK  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic        inject_err_in,
  output logic        de_out,
  output logic        de_first_offset_line_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic [23:0] data_out,
  output logic [31:0] frame_cnt_out,
  output logic        busy_out
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = 1 + V_ACTIVE + V_BLANK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_POS = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DATA_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_ROW = VW'(V_ACTIVE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [HW-1:0] h_cnt_reg, h_cnt_next;
  logic [VW-1:0] v_cnt_reg, v_cnt_next;
  logic [31:0]   frame_cnt_reg, frame_cnt_next;
  logic          pending_reg, pending_next;

  logic          de_reg, de_next;
  logic          first_reg, first_next;
  logic          hs_reg, hs_next;
  logic          vs_reg, vs_next;
  logic [23:0]   data_reg, data_next;
  logic          busy_reg, busy_next;

  logic active, line_end, frame_end, hdr_row, data_row, apply_err;

  always_comb begin
    state_next     = state_reg;
    h_cnt_next     = h_cnt_reg;
    v_cnt_next     = v_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    de_next        = 1'b0;
    first_next     = 1'b0;
    hs_next        = 1'b0;
    vs_next        = 1'b0;
    data_next      = 24'h0;

    active    = (state_reg != IDLE);
    line_end  = (h_cnt_reg == H_LAST);
    frame_end = line_end && (v_cnt_reg == V_LAST);
    hdr_row   = (v_cnt_reg == '0);
    data_row  = !hdr_row && (v_cnt_reg <= V_DATA_END);
    apply_err = pending_reg && active && data_row && (h_cnt_reg == '0);
    // A pulse coinciding with an application re-arms the flag for the next data row
    pending_next = (pending_reg && !apply_err) || inject_err_in;

    if (active) begin
      de_next    = (h_cnt_reg < H_SYNC_POS) && (hdr_row || data_row);
      first_next = de_next && hdr_row;
      hs_next    = (h_cnt_reg == H_SYNC_POS);
      vs_next    = (v_cnt_reg == V_SYNC_ROW) && (h_cnt_reg == '0);
      if (de_next) begin
        data_next = hdr_row ? {16'h8000, 8'(h_cnt_reg)}
                            : {frame_cnt_reg[7:0], 16'(v_cnt_reg)};
      end
      data_next[0] = data_next[0] ^ apply_err;
    end

    unique case (state_reg)
      IDLE: begin
        if (enable_in) begin
          state_next     = RUN;
          frame_cnt_next = frame_cnt_reg + 32'd1;
        end
      end
      RUN, DRAIN: begin
        if (frame_end) begin
          h_cnt_next = '0;
          v_cnt_next = '0;
          if (enable_in) begin
            state_next     = RUN;
            frame_cnt_next = frame_cnt_reg + 32'd1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          h_cnt_next = line_end ? '0 : h_cnt_reg + 1'b1;
          v_cnt_next = line_end ? v_cnt_reg + 1'b1 : v_cnt_reg;
          state_next = enable_in ? RUN : DRAIN;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      frame_cnt_reg <= '0;
      pending_reg   <= 1'b0;
      de_reg        <= 1'b0;
      first_reg     <= 1'b0;
      hs_reg        <= 1'b0;
      vs_reg        <= 1'b0;
      data_reg      <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      h_cnt_reg     <= h_cnt_next;
      v_cnt_reg     <= v_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      pending_reg   <= pending_next;
      de_reg        <= de_next;
      first_reg     <= first_next;
      hs_reg        <= hs_next;
      vs_reg        <= vs_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
    end
  end

  assign de_out                   = de_reg;
  assign de_first_offset_line_out = first_reg;
  assign h_sync_out               = hs_reg;
  assign v_sync_out               = vs_reg;
  assign data_out                 = data_reg;
  assign frame_cnt_out            = frame_cnt_reg;
  assign busy_out                 = busy_reg;
endmodule
